axi_lite_master: RTL and testbench
==================================

# axi_lite_master

AXI-Lite-style initiator that drives the read-address, read-data, write-address and write-data channels of the team's 4-bit AXI slave. It uses the same `ms_*`/`sm_*` handshake signal set that the slave exposes on the Tiny Tapeout pins. A simple command port accepts one read or write at a time and returns a single-cycle response carrying read data or a timeout error. This lets an on-chip sequencer or pin-level controller exercise the slave without toggling handshakes by hand.

## Interface
- `ADDR_W`, default 4: address width.
- `DATA_W`, default 4: data width.
- `TIMEOUT`, default 15: maximum wait cycles per handshake; 0 disables timeout.

Ports:
- `clk`  in  1: single clock; everything on rising edge.
- `reset`  in  1: one clock; reset is asynchronous and active-high.
- `cmd_valid`  in  1: command request.
- `cmd_ready`  out  1: high only in IDLE.
- `cmd_write`  in  1: 1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W: target address.
- `cmd_wdata`  in  DATA_W: write data.
- `rsp_valid`  out  1: one-cycle completion pulse.
- `rsp_err`  out  1: timeout flag; valid with `rsp_valid`.
- `rsp_rdata`  out  DATA_W: last successfully read data (held).
- `ms_arvalid` out 1, `ms_araddr` out ADDR_W, `sm_arready` in 1: read-address channel.
- `sm_rvalid` in 1, `sm_rdata` in DATA_W, `ms_rready` out 1: read-data channel.
- `ms_awvalid` out 1, `ms_awaddr` out ADDR_W, `sm_awready` in 1: write-address channel.
- `ms_wvalid` out 1, `ms_wdata` out DATA_W, `sm_wready` in 1: write-data channel.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch addr/wdata/write.
  - Go to RD_ADDR (read) or WR (write).
- RD_ADDR:
  - `ms_arvalid`=1 and `ms_araddr`=latched addr.
  - On `sm_arready`, go to RD_DATA.
- RD_DATA:
  - `ms_rready`=1 (asserted only in this state).
  - On `sm_rvalid`, capture `sm_rdata` into `rsp_rdata` and go to RESP with err=0.
- WR:
  - `ms_awvalid` and `ms_wvalid` both assert on entry.
  - Each drops independently the cycle after its own handshake (`ms_awvalid&sm_awready`, `ms_wvalid&sm_wready`). Either order or simultaneous is legal.
  - When both are done, go to RESP with err=0.
- RESP:
  - `rsp_valid`=1 for exactly one cycle.
  - Go to IDLE.
- Channel rules:
  - Once a valid is asserted, it and its address/data stay asserted and stable until handshake or timeout abort.
  - No combinational path from any `sm_*` input to any `ms_*` output.
- Timeout:
  - The counter clears on entry to RD_ADDR/RD_DATA/WR and on any handshake.
  - It increments each wait cycle without a handshake.
  - When it reaches TIMEOUT with no handshake that cycle, all `ms_*` valids/ready drop and the FSM goes to RESP with err=1.
  - `rsp_rdata` is unchanged on error.
- Ignored inputs: `cmd_valid` outside IDLE is ignored; no queueing.
- `rsp_rdata` is updated only by successful reads. Writes leave it unchanged.

## Timing
- Reset values:
  - State IDLE, `cmd_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - All `ms_*` valids and `ms_rready` = 0; `ms_araddr`, `ms_awaddr`, `ms_wdata` = 0.
- Read with a zero-wait slave:
  - Command accepted at edge 0.
  - `ms_arvalid` high in cycle 1 and handshake at edge 1.
  - `ms_rready` high in cycle 2 and data captured at edge 2.
  - `rsp_valid` high in cycle 3.
  - `cmd_ready` high again in cycle 4.
- Write with a zero-wait slave:
  - aw and w handshakes both in cycle 1.
  - `rsp_valid` in cycle 2.
  - `cmd_ready` in cycle 3.
- Each wait cycle on a handshake adds one cycle.
- Timeout: `rsp_valid`/`rsp_err` assert TIMEOUT+1 cycles after the last handshake or state entry.
- Reset mid-transaction:
  - All outputs return to reset values immediately (asynchronous).
  - No `rsp_valid` for the aborted command.
  - Next command accepted on the first edge after reset deasserts.

## Test plan
- Read, slave zero-wait, `cmd_addr`=4'h5, `sm_rdata`=4'hA:
  - `ms_araddr`=5 in cycle 1.
  - `rsp_valid` in cycle 3 with `rsp_rdata`=A and `rsp_err`=0.
- Read with `sm_arready` delayed 3 cycles and `sm_rvalid` delayed 2:
  - `ms_arvalid` and `ms_araddr` held stable for 4 cycles.
  - `ms_rready` held until rvalid.
  - `rsp_valid` in cycle 8.
- Write, addr 4'h3, data 4'hC, `sm_wready` 2 cycles before `sm_awready`:
  - `ms_wvalid` drops first while `ms_awvalid` stays high.
  - Single `rsp_valid` after awready.
  - `rsp_rdata` unchanged.
- Read with `sm_arready` tied low, TIMEOUT=15:
  - `ms_arvalid` drops.
  - `rsp_valid`=1 with `rsp_err`=1 at cycle 17.
  - `rsp_rdata` keeps its previous value.
- `cmd_valid` held high continuously through two reads:
  - Second command accepted only in the IDLE cycle after RESP.
  - Commands presented while busy produce no extra transactions.
- `reset` pulsed while in RD_DATA:
  - `ms_rready` and `cmd_ready` go to reset values without waiting for a clock edge.
  - No `rsp_valid`.
  - A subsequent read completes normally.

Source files
------------

// File: rtl/axi_lite_master.sv
// AXI-Lite-style initiator for the 4-bit AXI slave.
// Takes one read or write command at a time. Drives the ar/r or aw/w channels,
// then returns a single-cycle response carrying a timeout error flag.
// Every ms_* output comes from a register or from the state, so no sm_* input
// reaches an ms_* output through combinational logic.
module axi_lite_master #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  // command / response port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  // read-address channel
  output logic              ms_arvalid,
  output logic [ADDR_W-1:0] ms_araddr,
  input  logic              sm_arready,
  // read-data channel
  input  logic              sm_rvalid,
  input  logic [DATA_W-1:0] sm_rdata,
  output logic              ms_rready,
  // write-address channel
  output logic              ms_awvalid,
  output logic [ADDR_W-1:0] ms_awaddr,
  input  logic              sm_awready,
  // write-data channel
  output logic              ms_wvalid,
  output logic [DATA_W-1:0] ms_wdata,
  input  logic              sm_wready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR      = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  // A one-bit counter is kept when the timeout is disabled, so the width is never zero.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic ar_hs, r_hs, aw_hs, w_hs, any_hs, wr_done, tmo_hit;

  // Handshake and timeout conditions for the current cycle.
  always_comb begin
    ar_hs   = (state_q == S_RD_ADDR) && sm_arready;
    r_hs    = (state_q == S_RD_DATA) && sm_rvalid;
    aw_hs   = awvalid_q && sm_awready;
    w_hs    = wvalid_q && sm_wready;
    any_hs  = ar_hs || r_hs || aw_hs || w_hs;
    // A channel counts as finished if it completed earlier or completes this cycle.
    wr_done = (!awvalid_q || sm_awready) && (!wvalid_q || sm_wready);
    tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. The error flag is decided on the transition into RESP.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) state_d = cmd_write ? S_WR : S_RD_ADDR;
      end
      S_RD_ADDR: begin
        if (ar_hs) begin
          state_d = S_RD_DATA;
        end else if (tmo_hit) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (r_hs) begin
          state_d = S_RESP;
          err_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_WR: begin
        if (wr_done) begin
          state_d = S_RESP;
          err_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  // Next values for the command latch, write valids, read data and wait counter.
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    cnt_d     = cnt_q;

    if (state_q == S_IDLE && cmd_valid) begin
      addr_d  = cmd_addr;
      wdata_d = cmd_wdata;
    end

    // Both write valids rise together on entry to WR.
    // Each falls after its own handshake, or when WR is left because of a timeout.
    if (state_q == S_IDLE && state_d == S_WR) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
    end else begin
      if (aw_hs || state_d != S_WR) awvalid_d = 1'b0;
      if (w_hs  || state_d != S_WR) wvalid_d  = 1'b0;
    end

    if (r_hs) rdata_d = sm_rdata;

    // Count wait cycles. Restart on any state change or on any handshake.
    if (state_d != state_q || any_hs) begin
      cnt_d = '0;
    end else if (TIMEOUT != 0 && !tmo_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      cnt_q     <= cnt_d;
    end
  end

  // Outputs are decoded from the state and registers only.
  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    ms_arvalid = (state_q == S_RD_ADDR);
    ms_rready  = (state_q == S_RD_DATA);
    ms_awvalid = awvalid_q;
    ms_wvalid  = wvalid_q;
    ms_araddr  = addr_q;
    ms_awaddr  = addr_q;
    ms_wdata   = wdata_q;
    rsp_valid  = (state_q == S_RESP);
    rsp_err    = (state_q == S_RESP) && err_q;
    rsp_rdata  = rdata_q;
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master.
// The bench drives the slave handshakes by hand, cycle by cycle.
// Outputs are checked 1 ns after each rising edge.
module tb_axi_lite_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [3:0] rsp_rdata;
  logic       ms_arvalid, sm_arready;
  logic [3:0] ms_araddr;
  logic       sm_rvalid, ms_rready;
  logic [3:0] sm_rdata;
  logic       ms_awvalid, sm_awready;
  logic [3:0] ms_awaddr;
  logic       ms_wvalid, sm_wready;
  logic [3:0] ms_wdata;

  int n_assert = 0;
  int n_fail   = 0;

  axi_lite_master #(.ADDR_W(4), .DATA_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .ms_arvalid(ms_arvalid), .ms_araddr(ms_araddr), .sm_arready(sm_arready),
    .sm_rvalid(sm_rvalid), .sm_rdata(sm_rdata), .ms_rready(ms_rready),
    .ms_awvalid(ms_awvalid), .ms_awaddr(ms_awaddr), .sm_awready(sm_awready),
    .ms_wvalid(ms_wvalid), .ms_wdata(ms_wdata), .sm_wready(sm_wready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_wdata = 4'h0;
    sm_arready = 1'b0; sm_rvalid = 1'b0; sm_rdata = 4'h0; sm_awready = 1'b0; sm_wready = 1'b0;

    // Reset values
    tick(); tick();
    check("rst cmd_ready", 8'(cmd_ready), 8'h1);
    check("rst rsp_valid", 8'(rsp_valid), 8'h0);
    check("rst rsp_err",   8'(rsp_err),   8'h0);
    check("rst rsp_rdata", 8'(rsp_rdata), 8'h0);
    check("rst valids", 8'({ms_arvalid, ms_rready, ms_awvalid, ms_wvalid}), 8'h0);
    check("rst addrs", 8'({ms_araddr, ms_awaddr}), 8'h00);
    check("rst wdata", 8'(ms_wdata), 8'h0);
    reset = 1'b0;
    tick();

    // 1: read from a zero-wait slave, addr 5 returns data A
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h5;
    sm_arready = 1'b1; sm_rvalid = 1'b1; sm_rdata = 4'hA;
    check("t1 c0 cmd_ready", 8'(cmd_ready), 8'h1);
    tick();
    cmd_valid = 1'b0;
    check("t1 c1 arvalid", 8'(ms_arvalid), 8'h1);
    check("t1 c1 araddr", 8'(ms_araddr), 8'h5);
    check("t1 c1 cmd_ready", 8'(cmd_ready), 8'h0);
    tick();
    check("t1 c2 rready", 8'(ms_rready), 8'h1);
    check("t1 c2 arvalid", 8'(ms_arvalid), 8'h0);
    tick();
    check("t1 c3 rsp_valid", 8'(rsp_valid), 8'h1);
    check("t1 c3 rsp_err", 8'(rsp_err), 8'h0);
    check("t1 c3 rsp_rdata", 8'(rsp_rdata), 8'hA);
    tick();
    check("t1 c4 cmd_ready", 8'(cmd_ready), 8'h1);
    check("t1 c4 rsp_valid", 8'(rsp_valid), 8'h0);
    sm_arready = 1'b0; sm_rvalid = 1'b0;

    // 2: read addr 9 with arready 3 cycles late and rvalid 2 cycles late, data 6
    cmd_valid = 1'b1; cmd_addr = 4'h9;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      sm_arready = (c == 4);
      sm_rvalid  = (c == 7);
      sm_rdata   = 4'h6;
      check($sformatf("t2 c%0d arvalid", c), 8'(ms_arvalid), 8'(c <= 4));
      if (c <= 4) check($sformatf("t2 c%0d araddr", c), 8'(ms_araddr), 8'h9);
      check($sformatf("t2 c%0d rready", c), 8'(ms_rready), 8'(c >= 5 && c <= 7));
      check($sformatf("t2 c%0d rsp_valid", c), 8'(rsp_valid), 8'(c == 8));
      if (c < 8) tick();
    end
    sm_arready = 1'b0; sm_rvalid = 1'b0;
    check("t2 rsp_rdata", 8'(rsp_rdata), 8'h6);
    check("t2 rsp_err", 8'(rsp_err), 8'h0);
    tick();

    // 3: write addr 3, data C, wready two cycles before awready
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h3; cmd_wdata = 4'hC;
    tick();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_wdata = 4'h0;
    for (int c = 1; c <= 5; c++) begin
      sm_wready  = (c == 1);
      sm_awready = (c == 3);
      check($sformatf("t3 c%0d awvalid", c), 8'(ms_awvalid), 8'(c <= 3));
      check($sformatf("t3 c%0d wvalid", c), 8'(ms_wvalid), 8'(c == 1));
      if (c <= 3) check($sformatf("t3 c%0d awaddr", c), 8'(ms_awaddr), 8'h3);
      if (c == 1) check("t3 c1 wdata", 8'(ms_wdata), 8'hC);
      check($sformatf("t3 c%0d rsp_valid", c), 8'(rsp_valid), 8'(c == 4));
      check($sformatf("t3 c%0d rsp_rdata", c), 8'(rsp_rdata), 8'h6);
      if (c == 4) check("t3 c4 rsp_err", 8'(rsp_err), 8'h0);
      tick();
    end
    sm_wready = 1'b0; sm_awready = 1'b0;

    // 4: read addr 2 while arready stays low, so the timeout fires
    cmd_valid = 1'b1; cmd_addr = 4'h2;
    check("t4 c0 cmd_ready", 8'(cmd_ready), 8'h1);
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      check($sformatf("t4 c%0d arvalid", c), 8'(ms_arvalid), 8'(c <= 16));
      if (c <= 16) check($sformatf("t4 c%0d araddr", c), 8'(ms_araddr), 8'h2);
      check($sformatf("t4 c%0d rready", c), 8'(ms_rready), 8'h0);
      check($sformatf("t4 c%0d rsp_valid", c), 8'(rsp_valid), 8'(c == 17));
      check($sformatf("t4 c%0d rsp_err", c), 8'(rsp_err), 8'(c == 17));
      if (c == 17) check("t4 rsp_rdata", 8'(rsp_rdata), 8'h6);
      if (c < 18) tick();
    end
    check("t4 c18 cmd_ready", 8'(cmd_ready), 8'h1);

    // 5: cmd_valid held high through two back-to-back reads
    cmd_valid = 1'b1; cmd_addr = 4'h1;
    sm_arready = 1'b1; sm_rvalid = 1'b1; sm_rdata = 4'h4;
    tick();
    for (int c = 1; c <= 8; c++) begin
      cmd_valid = (c <= 4);
      cmd_addr  = 4'h7;
      sm_rdata  = (c <= 2) ? 4'h4 : 4'h3;
      check($sformatf("t5 c%0d arvalid", c), 8'(ms_arvalid), 8'(c == 1 || c == 5));
      if (c == 1) check("t5 c1 araddr", 8'(ms_araddr), 8'h1);
      if (c == 5) check("t5 c5 araddr", 8'(ms_araddr), 8'h7);
      check($sformatf("t5 c%0d rready", c), 8'(ms_rready), 8'(c == 2 || c == 6));
      check($sformatf("t5 c%0d rsp_valid", c), 8'(rsp_valid), 8'(c == 3 || c == 7));
      check($sformatf("t5 c%0d cmd_ready", c), 8'(cmd_ready), 8'(c == 4 || c == 8));
      check($sformatf("t5 c%0d awvalid", c), 8'(ms_awvalid), 8'h0);
      if (c == 3) check("t5 c3 rsp_rdata", 8'(rsp_rdata), 8'h4);
      if (c == 7) check("t5 c7 rsp_rdata", 8'(rsp_rdata), 8'h3);
      if (c < 8) tick();
    end
    cmd_valid = 1'b0; sm_arready = 1'b0; sm_rvalid = 1'b0;
    tick();

    // 6: pulse reset while the master sits in RD_DATA
    cmd_valid = 1'b1; cmd_addr = 4'hB; sm_arready = 1'b1; sm_rvalid = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("t6 c1 arvalid", 8'(ms_arvalid), 8'h1);
    tick();
    check("t6 c2 rready", 8'(ms_rready), 8'h1);
    check("t6 c2 cmd_ready", 8'(cmd_ready), 8'h0);
    #2 reset = 1'b1;
    #1;
    check("t6 async rready", 8'(ms_rready), 8'h0);
    check("t6 async cmd_ready", 8'(cmd_ready), 8'h1);
    check("t6 async araddr", 8'(ms_araddr), 8'h0);
    check("t6 async rsp_rdata", 8'(rsp_rdata), 8'h0);
    #1 reset = 1'b0;
    sm_arready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("t6 post%0d rsp_valid", c), 8'(rsp_valid), 8'h0);
      check($sformatf("t6 post%0d cmd_ready", c), 8'(cmd_ready), 8'h1);
    end
    cmd_valid = 1'b1; cmd_addr = 4'hD; sm_arready = 1'b1; sm_rvalid = 1'b1; sm_rdata = 4'h5;
    tick();
    cmd_valid = 1'b0;
    check("t6 r c1 araddr", 8'(ms_araddr), 8'hD);
    tick();
    check("t6 r c2 rready", 8'(ms_rready), 8'h1);
    tick();
    check("t6 r c3 rsp_valid", 8'(rsp_valid), 8'h1);
    check("t6 r c3 rsp_err", 8'(rsp_err), 8'h0);
    check("t6 r c3 rsp_rdata", 8'(rsp_rdata), 8'h5);
    tick();
    check("t6 r c4 cmd_ready", 8'(cmd_ready), 8'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
